// File: rtl/port_ingress_fifo.sv
// rtl/port_ingress_fifo.sv - per-port ingress FIFO with loopback filtering and drop statistics
//
// Purpose:
//   Buffers packets arriving from a valid-only port interface into a DEPTH-entry
//   first-word-fall-through FIFO and offers them to the switch fabric through a
//   valid/ready handshake. Packets addressed to this port are discarded and
//   counted as loopback, and packets that arrive while the FIFO is full with no
//   pop in the same cycle are discarded and counted as drops.
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   rst_n       asynchronous active-low reset
//   valid_in    packet present on source_in/target_in/data_in (no backpressure)
//   source_in   packet source port
//   target_in   packet destination port
//   data_in     packet payload
//   valid_out   head-of-FIFO packet is valid toward the fabric
//   ready_out   fabric accepts the head packet this cycle
//   source_out  head packet source (0 when empty)
//   target_out  head packet target (0 when empty)
//   data_out    head packet payload (0 when empty)
//   count       entries currently stored
//   full        count == DEPTH
//   empty       count == 0
//   drop_cnt    saturating count of packets discarded because the FIFO was full
//   loop_cnt    saturating count of packets discarded as loopback

module port_ingress_fifo #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 4,
    parameter int DEPTH   = 4,
    parameter int PORT_ID = 0,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     valid_in,
    input  logic [ADDR_W-1:0]        source_in,
    input  logic [ADDR_W-1:0]        target_in,
    input  logic [DATA_W-1:0]        data_in,
    output logic                     valid_out,
    input  logic                     ready_out,
    output logic [ADDR_W-1:0]        source_out,
    output logic [ADDR_W-1:0]        target_out,
    output logic [DATA_W-1:0]        data_out,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic [CNT_W-1:0]         loop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    localparam logic [OCC_W-1:0]  DEPTH_C   = OCC_W'(DEPTH);
    localparam logic [ADDR_W-1:0] OWN_ADDR  = ADDR_W'(PORT_ID);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    // Storage is split per field so each array maps onto a plain register file.
    logic [ADDR_W-1:0] src_mem  [DEPTH];
    logic [ADDR_W-1:0] tgt_mem  [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;

    logic is_full;
    logic is_empty;
    logic loopback;
    logic pop;
    logic push;
    logic overflow;

    assign is_full  = (occ == DEPTH_C);
    assign is_empty = (occ == '0);

    // Loopback is decided before the capacity check, so a loopback packet
    // never shows up in drop_cnt even when the FIFO is full.
    assign loopback = valid_in && (target_in == OWN_ADDR);

    // A pop frees a slot in the same cycle, which lets a full FIFO still
    // accept an incoming packet without losing it.
    assign pop      = !is_empty && ready_out;
    assign push     = valid_in && !loopback && (!is_full || pop);
    assign overflow = valid_in && !loopback && is_full && !pop;

    // Payload storage carries no reset: the outputs are masked while empty,
    // so stale contents are never observable.
    always_ff @(posedge clk) begin
        if (push) begin
            src_mem[wr_ptr]  <= source_in;
            tgt_mem[wr_ptr]  <= target_in;
            data_mem[wr_ptr] <= data_in;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; occupancy is
    // tracked separately so full and empty never alias.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Statistics counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
            loop_cnt <= '0;
        end else begin
            if (overflow && (drop_cnt != CNT_MAX)) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
            end
            if (loopback && (loop_cnt != CNT_MAX)) begin
                loop_cnt <= loop_cnt + CNT_W'(1);
            end
        end
    end

    // First-word-fall-through view of the head entry. These depend only on
    // registered state, so there is no path from the input side to the
    // outputs and the head stays put while the fabric stalls.
    assign valid_out  = !is_empty;
    assign source_out = is_empty ? '0 : src_mem[rd_ptr];
    assign target_out = is_empty ? '0 : tgt_mem[rd_ptr];
    assign data_out   = is_empty ? '0 : data_mem[rd_ptr];

    assign count = occ;
    assign full  = is_full;
    assign empty = is_empty;

endmodule

// File: tb/tb_port_ingress_fifo.sv
// tb/tb_port_ingress_fifo.sv - table-driven self-checking bench for port_ingress_fifo

module tb_port_ingress_fifo;

    logic       clk;
    logic       rst_n;
    logic       valid_in;
    logic [3:0] source_in;
    logic [3:0] target_in;
    logic [7:0] data_in;
    logic       valid_out;
    logic       ready_out;
    logic [3:0] source_out;
    logic [3:0] target_out;
    logic [7:0] data_out;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic [3:0] drop_cnt;
    logic [3:0] loop_cnt;

    int n_vec;
    int n_err;

    port_ingress_fifo #(
        .DATA_W (8),
        .ADDR_W (4),
        .DEPTH  (4),
        .PORT_ID(3),
        .CNT_W  (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .source_in (source_in),
        .target_in (target_in),
        .data_in   (data_in),
        .valid_out (valid_out),
        .ready_out (ready_out),
        .source_out(source_out),
        .target_out(target_out),
        .data_out  (data_out),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .drop_cnt  (drop_cnt),
        .loop_cnt  (loop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       vin;
        logic [3:0] src;
        logic [3:0] tgt;
        logic [7:0] data;
        logic       rdy;
        logic       ev;
        logic [3:0] es;
        logic [3:0] et;
        logic [7:0] ed;
        logic [2:0] ec;
        logic [3:0] edrop;
        logic [3:0] eloop;
    } vec_t;

    vec_t vt[33];

    function automatic vec_t mk(logic vin, logic [3:0] src, logic [3:0] tgt, logic [7:0] data,
                                logic rdy, logic ev, logic [3:0] es, logic [3:0] et,
                                logic [7:0] ed, logic [2:0] ec, logic [3:0] edrop,
                                logic [3:0] eloop);
        vec_t v;
        v.vin = vin; v.src = src; v.tgt = tgt; v.data = data; v.rdy = rdy;
        v.ev = ev; v.es = es; v.et = et; v.ed = ed; v.ec = ec;
        v.edrop = edrop; v.eloop = eloop;
        return v;
    endfunction

    task automatic check(string name, logic ev, logic [3:0] es, logic [3:0] et, logic [7:0] ed,
                         logic [2:0] ec, logic [3:0] edrop, logic [3:0] eloop);
        logic [30:0] got;
        logic [30:0] exp;
        got = {valid_out, source_out, target_out, data_out, count, full, empty, drop_cnt, loop_cnt};
        exp = {ev, es, et, ed, ec, (ec == 3'd4), (ec == 3'd0), edrop, eloop};
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got v=%0b s=%h t=%h d=%h cnt=%0d f=%0b e=%0b drop=%0d loop=%0d, want v=%0b s=%h t=%h d=%h cnt=%0d f=%0b e=%0b drop=%0d loop=%0d",
                     name, valid_out, source_out, target_out, data_out, count, full, empty,
                     drop_cnt, loop_cnt, ev, es, et, ed, ec, (ec == 3'd4), (ec == 3'd0),
                     edrop, eloop);
        end
    endtask

    task automatic drive(logic vin, logic [3:0] src, logic [3:0] tgt, logic [7:0] data, logic rdy);
        valid_in  = vin;
        source_in = src;
        target_in = tgt;
        data_in   = data;
        ready_out = rdy;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(1'b0, 4'h0, 4'h0, 8'h00, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        drive(1'b0, 4'h0, 4'h0, 8'h00, 1'b0);

        // Single packet, loaded FIFO with overflow, full+pop+push, loopback filtering.
        vt[0]  = mk(1, 1, 2, 8'hA5, 1,  0, 0, 0, 8'h00, 0, 0, 0);
        vt[1]  = mk(0, 0, 0, 8'h00, 1,  1, 1, 2, 8'hA5, 1, 0, 0);
        vt[2]  = mk(0, 0, 0, 8'h00, 0,  0, 0, 0, 8'h00, 0, 0, 0);
        vt[3]  = mk(1, 2, 1, 8'h10, 0,  0, 0, 0, 8'h00, 0, 0, 0);
        vt[4]  = mk(1, 2, 1, 8'h11, 0,  1, 2, 1, 8'h10, 1, 0, 0);
        vt[5]  = mk(1, 2, 1, 8'h12, 0,  1, 2, 1, 8'h10, 2, 0, 0);
        vt[6]  = mk(1, 2, 1, 8'h13, 0,  1, 2, 1, 8'h10, 3, 0, 0);
        vt[7]  = mk(1, 2, 1, 8'h14, 0,  1, 2, 1, 8'h10, 4, 0, 0);
        vt[8]  = mk(1, 2, 1, 8'h15, 0,  1, 2, 1, 8'h10, 4, 1, 0);
        vt[9]  = mk(0, 0, 0, 8'h00, 1,  1, 2, 1, 8'h10, 4, 2, 0);
        vt[10] = mk(0, 0, 0, 8'h00, 1,  1, 2, 1, 8'h11, 3, 2, 0);
        vt[11] = mk(0, 0, 0, 8'h00, 1,  1, 2, 1, 8'h12, 2, 2, 0);
        vt[12] = mk(0, 0, 0, 8'h00, 1,  1, 2, 1, 8'h13, 1, 2, 0);
        vt[13] = mk(0, 0, 0, 8'h00, 0,  0, 0, 0, 8'h00, 0, 2, 0);
        vt[14] = mk(1, 2, 1, 8'h20, 0,  0, 0, 0, 8'h00, 0, 2, 0);
        vt[15] = mk(1, 2, 1, 8'h21, 0,  1, 2, 1, 8'h20, 1, 2, 0);
        vt[16] = mk(1, 2, 1, 8'h22, 0,  1, 2, 1, 8'h20, 2, 2, 0);
        vt[17] = mk(1, 2, 1, 8'h23, 0,  1, 2, 1, 8'h20, 3, 2, 0);
        vt[18] = mk(1, 2, 1, 8'h77, 1,  1, 2, 1, 8'h20, 4, 2, 0);
        vt[19] = mk(0, 0, 0, 8'h00, 0,  1, 2, 1, 8'h21, 4, 2, 0);
        vt[20] = mk(0, 0, 0, 8'h00, 1,  1, 2, 1, 8'h21, 4, 2, 0);
        vt[21] = mk(0, 0, 0, 8'h00, 1,  1, 2, 1, 8'h22, 3, 2, 0);
        vt[22] = mk(0, 0, 0, 8'h00, 1,  1, 2, 1, 8'h23, 2, 2, 0);
        vt[23] = mk(0, 0, 0, 8'h00, 1,  1, 2, 1, 8'h77, 1, 2, 0);
        vt[24] = mk(0, 0, 0, 8'h00, 0,  0, 0, 0, 8'h00, 0, 2, 0);
        vt[25] = mk(1, 5, 3, 8'h30, 1,  0, 0, 0, 8'h00, 0, 2, 0);
        vt[26] = mk(1, 5, 0, 8'h40, 1,  0, 0, 0, 8'h00, 0, 2, 1);
        vt[27] = mk(1, 5, 3, 8'h31, 1,  1, 5, 0, 8'h40, 1, 2, 1);
        vt[28] = mk(1, 5, 0, 8'h41, 1,  0, 0, 0, 8'h00, 0, 2, 2);
        vt[29] = mk(1, 5, 3, 8'h32, 1,  1, 5, 0, 8'h41, 1, 2, 2);
        vt[30] = mk(1, 5, 3, 8'h33, 1,  0, 0, 0, 8'h00, 0, 2, 3);
        vt[31] = mk(1, 5, 3, 8'h34, 1,  0, 0, 0, 8'h00, 0, 2, 4);
        vt[32] = mk(0, 0, 0, 8'h00, 0,  0, 0, 0, 8'h00, 0, 2, 5);

        @(negedge clk);
        @(negedge clk);
        check("reset", 0, 0, 0, 8'h00, 0, 0, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 33; i++) begin
            @(negedge clk);
            drive(vt[i].vin, vt[i].src, vt[i].tgt, vt[i].data, vt[i].rdy);
            check($sformatf("vec%0d", i), vt[i].ev, vt[i].es, vt[i].et, vt[i].ed,
                  vt[i].ec, vt[i].edrop, vt[i].eloop);
        end

        // Backpressure: head must hold for 10 stalled cycles while pushes keep arriving.
        do_reset();
        @(negedge clk);
        drive(1, 5, 1, 8'h50, 0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            drive(1, 5, 1, 8'h50 + 8'(k), 0);
            check($sformatf("hold%0d", k), 1, 5, 1, 8'h50, (k < 4) ? 3'(k) : 3'd4,
                  (k < 5) ? 4'd0 : 4'(k - 4), 0);
        end
        @(negedge clk);
        drive(0, 0, 0, 8'h00, 0);
        check("hold_end", 1, 5, 1, 8'h50, 4, 7, 0);

        // Saturation: 20 more drops push the 4-bit counter past its ceiling.
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            drive(1, 6, 1, 8'hEE, 0);
        end
        @(negedge clk);
        drive(0, 0, 0, 8'h00, 0);
        check("drop_sat", 1, 5, 1, 8'h50, 4, 15, 0);

        // Asynchronous reset between edges while holding 3 entries and valid_in high.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(1, 2, 1, 8'h60 + 8'(k), 0);
        end
        @(negedge clk);
        drive(1, 2, 1, 8'h63, 0);
        check("pre_rst", 1, 2, 1, 8'h60, 3, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", 0, 0, 0, 8'h00, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 8'h00, 0);
        rst_n = 1'b1;
        @(negedge clk);
        drive(1, 7, 2, 8'h99, 1);
        @(negedge clk);
        drive(0, 0, 0, 8'h00, 1);
        check("post_rst", 1, 7, 2, 8'h99, 1, 0, 0);
        @(negedge clk);
        check("post_rst_empty", 0, 0, 0, 8'h00, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/port_ingress_fifo.md
Name: port_ingress_fifo

Overview:
Per-port ingress buffer for the network switch, generalising the single-cycle port handshake. It accepts packets (source, target, data) from the port's valid-only input side and stores them in a DEPTH-entry FIFO. It presents them to the switch fabric over a valid/ready handshake with backpressure. Overflowing packets and loopback packets (target equals own port) are discarded and counted.

Parameters:
DATA_W, 8, payload width in bits
ADDR_W, 4, width of source/target port address
DEPTH, 4, FIFO entries; power of 2, >= 2
PORT_ID, 0, this port's address; a packet with target_in == PORT_ID is a loopback
CNT_W, 16, width of the drop/loopback statistics counters

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
valid_in  input  1  packet present on source_in/target_in/data_in this cycle (no backpressure)
source_in  input  ADDR_W  packet source port
target_in  input  ADDR_W  packet destination port
data_in  input  DATA_W  packet payload
valid_out  output  1  head-of-FIFO packet valid toward fabric
ready_out  input  1  fabric accepts head packet this cycle
source_out  output  ADDR_W  head packet source
target_out  output  ADDR_W  head packet target
data_out  output  DATA_W  head packet payload
count  output  $clog2(DEPTH)+1  entries currently stored
full  output  1  count == DEPTH
empty  output  1  count == 0
drop_cnt  output  CNT_W  packets discarded due to full FIFO
loop_cnt  output  CNT_W  packets discarded as loopback

Behaviour:
- Reset (rst_n low, asynchronous): FIFO cleared (pointers 0, count 0); valid_out=0, full=0, empty=1, drop_cnt=0, loop_cnt=0; source_out/target_out/data_out=0. Any packet in flight is lost; the first valid_in sampled after deassertion is handled normally.
- pop = valid_out && ready_out.
- push is the case valid_in && target_in != PORT_ID && (count < DEPTH || pop).
- Loopback: valid_in && target_in == PORT_ID -> not stored; loop_cnt += 1. Loopback takes priority over the full check, so drop_cnt is not incremented for loopback packets.
- Overflow: valid_in, not loopback, count == DEPTH and !pop -> not stored; drop_cnt += 1.
- Full with simultaneous pop: packet is accepted and count stays DEPTH.
- Counters saturate at all-ones; no wrap.
- Latency: a packet pushed at edge N is visible on the outputs with valid_out=1 in the cycle after edge N. There is no combinational bypass from inputs to outputs.
- Outputs are first-word-fall-through from storage: valid_out = !empty, and the *_out fields show the head entry.
- When empty, the *_out fields are forced to 0.
- While valid_out && !ready_out, all *_out fields must hold stable.
- ready_out while empty is ignored.
- Empty with simultaneous push: valid_out rises only in the following cycle; no pop is possible in the push cycle.
- Push and pop in the same cycle with 0 < count < DEPTH: count is unchanged and the head advances.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count tracks occupancy, so full and empty are unambiguous.
- Packet order is strictly preserved: in-order FIFO, no reordering across sources or targets.
- Source/target/data are stored as given; there is no address validation other than the loopback check.

Test Plan:
- Reset, then a single push of src=1, tgt=2, data=0xA5 with ready_out=1 -> valid_out high exactly 1 cycle after the push edge with fields 1/2/0xA5; popped in that cycle; empty=1 afterwards; both counters 0.
- ready_out=0, push 6 packets with data 0x10..0x15 on consecutive cycles (DEPTH=4) -> count=4, full=1, drop_cnt=2. Then ready_out=1 -> outputs 0x10,0x11,0x12,0x13 in order, then empty.
- FIFO full, ready_out=1 and valid_in=1 (data=0x77) in the same cycle -> head popped, 0x77 accepted, count stays 4, drop_cnt unchanged.
- PORT_ID=3, push tgt=3 five times interleaved with tgt=0 packets -> loop_cnt=5, only the tgt=0 packets emerge, drop_cnt=0.
- Backpressure hold: valid_out=1 with ready_out low for 10 cycles while new pushes arrive -> *_out stable all 10 cycles, head unchanged.
- Reset mid-operation: 3 entries stored and valid_in high, assert rst_n low asynchronously between edges -> valid_out=0, count=0, drop_cnt=0 immediately. After release, a fresh push emerges alone.
- Saturation: force >2^CNT_W overflow drops (CNT_W=4 build, 20 drops) -> drop_cnt holds 0xF.
